// File: rtl/pid_pkg.sv
// Shared widths and limits for the PID drive controller.
// Derived saturator widths keep the clamp ranges tied to the named limits.
package pid_pkg;
  localparam int ERR_W   = 13;
  localparam int INTEG_W = 17;
  localparam int PID_W   = 15;
  localparam int DRV_W   = 12;

  localparam logic [INTEG_W-1:0] INTEG_MAX = 17'h1FFFF;
  localparam int                 D_SAT_POS = 511;
  localparam int                 D_SAT_NEG = -512;
  localparam logic [DRV_W-1:0]   DRV_MAX   = 12'hFFF;

  // Signed widths whose natural range covers each clamp window.
  localparam int D_SAT_W     = $clog2(D_SAT_POS - D_SAT_NEG + 1);
  localparam int INTEG_SAT_W = $clog2(int'(INTEG_MAX) + 1) + 1;
  localparam int DRV_SAT_W   = $clog2(int'(DRV_MAX) + 1) + 1;
endpackage

// File: rtl/pid_sat.sv
// Signed saturator: clamps an IN_W-bit signed value into the OUT_W-bit signed range.
module pid_sat #(
  parameter int IN_W  = 14,
  parameter int OUT_W = 10
) (
  input  logic signed [IN_W-1:0]  in_i,
  output logic signed [OUT_W-1:0] out_o
);
  localparam logic signed [IN_W-1:0] MAX_V = IN_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [IN_W-1:0] MIN_V = IN_W'(-(2 ** (OUT_W - 1)));

  always_comb begin
    if (in_i > MAX_V) begin
      out_o = MAX_V[OUT_W-1:0];
    end else if (in_i < MIN_V) begin
      out_o = MIN_V[OUT_W-1:0];
    end else begin
      out_o = in_i[OUT_W-1:0];
    end
  end
endmodule

// File: rtl/pid_drive_ctrl.sv
// Closed-loop PID drive controller: signed error in, registered unsigned drive magnitude out.
// Integrator and derivative history advance on a decimated tick; P acts every clock.
module pid_drive_ctrl
  import pid_pkg::*;
#(
  parameter int DEC_W   = 20,
  parameter int D_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [ERR_W-1:0] error,
  input  logic                    not_pedaling,
  output logic [DRV_W-1:0]        drv_mag
);
  logic [DEC_W-1:0]                  dec_q;
  logic signed [ERR_W-1:0]           err_q;
  logic                              tick_q;
  logic [INTEG_W-1:0]                integ_q, integ_d;
  logic [D_DEPTH-1:0][ERR_W-1:0]     hist_q, hist_d;
  logic [DRV_W-1:0]                  drv_q, drv_d;

  logic                              tick;
  logic signed [INTEG_SAT_W:0]       integ_sum;
  logic signed [INTEG_SAT_W-1:0]     integ_sat;
  logic signed [ERR_W:0]             d_diff;
  logic signed [D_SAT_W-1:0]         d_sat;
  logic signed [PID_W-1:0]           p_term, i_term, d_term, pid;
  logic signed [DRV_SAT_W-1:0]       drv_sat;

  assign tick = &dec_q;

  // 19-bit sum: integ near max plus a positive error overflows 18-bit signed.
  assign integ_sum = {2'b00, integ_q}
                   + {{(INTEG_SAT_W + 1 - ERR_W){err_q[ERR_W-1]}}, err_q};

  pid_sat #(.IN_W(INTEG_SAT_W + 1), .OUT_W(INTEG_SAT_W)) u_integ_sat (
    .in_i  (integ_sum),
    .out_o (integ_sat)
  );

  always_comb begin
    integ_d = integ_q;
    if (not_pedaling) begin
      integ_d = '0;
    end else if (tick_q) begin
      integ_d = integ_sat[INTEG_SAT_W-1] ? '0 : integ_sat[INTEG_W-1:0];
    end
  end

  always_comb begin
    hist_d = hist_q;
    if (tick_q) begin
      hist_d[0] = err_q;
      for (int k = 1; k < D_DEPTH; k++) begin
        hist_d[k] = hist_q[k-1];
      end
    end
  end

  assign d_diff = {err_q[ERR_W-1], err_q}
                - {hist_q[D_DEPTH-1][ERR_W-1], hist_q[D_DEPTH-1]};

  pid_sat #(.IN_W(ERR_W + 1), .OUT_W(D_SAT_W)) u_d_sat (
    .in_i  (d_diff),
    .out_o (d_sat)
  );

  assign p_term = {{(PID_W - ERR_W){err_q[ERR_W-1]}}, err_q};
  assign i_term = {{(PID_W - 12){1'b0}}, integ_q[INTEG_W-1:5]};
  assign d_term = {{(PID_W - D_SAT_W - 1){d_sat[D_SAT_W-1]}}, d_sat, 1'b0};
  assign pid    = p_term + i_term + d_term;

  pid_sat #(.IN_W(PID_W), .OUT_W(DRV_SAT_W)) u_drv_sat (
    .in_i  (pid),
    .out_o (drv_sat)
  );

  assign drv_d   = drv_sat[DRV_SAT_W-1] ? '0 : drv_sat[DRV_W-1:0];
  assign drv_mag = drv_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_q   <= '0;
      err_q   <= '0;
      tick_q  <= 1'b0;
      integ_q <= '0;
      hist_q  <= '0;
      drv_q   <= '0;
    end else begin
      dec_q   <= dec_q + 1'b1;
      err_q   <= error;
      tick_q  <= tick;
      integ_q <= integ_d;
      hist_q  <= hist_d;
      drv_q   <= drv_d;
    end
  end
endmodule
